io_irq_ctrl: RTL and testbench



---
 rtl/io_irq_ctrl_pkg.sv | 19 +
 rtl/io_irq_prio_enc.sv | 27 ++
 rtl/io_irq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_io_irq_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/io_irq_ctrl_pkg.sv
// io_irq_ctrl_pkg
//   Shared types and constants for the peripheral-bus interrupt controller.
//   - irq_state_t : controller FSM states
//   - *_OFS       : register offsets within the window (scaled by Address_Wording)
package io_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    IN_SERVICE = 2'd2
  } irq_state_t;

  localparam int PENDING_OFS = 0;
  localparam int ENABLE_OFS  = 1;
  localparam int VECTOR_OFS  = 2;
  localparam int EOI_OFS     = 3;
  localparam int SWTRIG_OFS  = 4;

endpackage

// File: rtl/io_irq_prio_enc.sv
// io_irq_prio_enc
//   Combinational lowest-index priority encoder.
//   Ports:
//     req   in  WIDTH : request vector
//     valid out 1     : any request set
//     index out IDXW  : index of the lowest set request (0 when none)
module io_irq_prio_enc
  import io_irq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDXW-1:0]  index
);

  // Scan high to low so the last (lowest) hit wins.
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) index = IDXW'(i);
    end
  end

endmodule

// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl
//   Interrupt controller for the CPU peripheral bus. Latches rising edges of
//   level irq lines as pending, picks the lowest enabled pending source and
//   sequences claim (VECTOR read) / end-of-interrupt (EOI write).
//   Ports:
//     clk_i           in  1             : clock
//     reset_i         in  1             : async active-high reset
//     address_i       in  address_width : bus address
//     data_i          in  data_width    : bus write data
//     rd_wr_i         in  1             : 0 = read, 1 = write
//     src_irq_i       in  Num_Sources   : peripheral irq lines (clk_i domain)
//     data_o          out data_width    : registered read data
//     take_controlr_o out 1             : read hit (registered)
//     take_controlw_o out 1             : write hit pulse (registered)
//     irq_o           out 1             : interrupt request, high in ASSERT
//   Registers at BaseAddress + n*Address_Wording:
//     0 PENDING (R/W1C), 1 ENABLE (R/W), 2 VECTOR (R, claim), 3 EOI (W),
//     4 SWTRIG (W, OR into PENDING)
module io_irq_ctrl
  import io_irq_ctrl_pkg::*;
#(
  parameter int unsigned BaseAddress     = 0,
  parameter int          address_width   = 16,
  parameter int          data_width      = 8,
  parameter int unsigned Address_Wording = 1,
  parameter int          Num_Sources     = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  input  logic [Num_Sources-1:0]   src_irq_i,
  output logic [data_width-1:0]    data_o,
  output logic                     take_controlr_o,
  output logic                     take_controlw_o,
  output logic                     irq_o
);

  localparam int NS   = Num_Sources;
  localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [address_width-1:0] A_PEND =
    address_width'(BaseAddress + PENDING_OFS * Address_Wording);
  localparam logic [address_width-1:0] A_EN   =
    address_width'(BaseAddress + ENABLE_OFS * Address_Wording);
  localparam logic [address_width-1:0] A_VEC  =
    address_width'(BaseAddress + VECTOR_OFS * Address_Wording);
  localparam logic [address_width-1:0] A_EOI  =
    address_width'(BaseAddress + EOI_OFS * Address_Wording);
  localparam logic [address_width-1:0] A_SW   =
    address_width'(BaseAddress + SWTRIG_OFS * Address_Wording);

  irq_state_t      state;
  logic [NS-1:0]   pending, enable, src_q;
  logic [NS-1:0]   set_m, clr_m, pend_nx, en_nx, live_nx;
  logic [IDXW-1:0] vec, enc_idx;
  logic            enc_valid;
  logic            rd, wr, claim;
  logic            hit_pend, hit_en, hit_vec, hit_eoi, hit_sw;
  logic [data_width-1:0] rdata;

  assign rd       = ~rd_wr_i;
  assign wr       =  rd_wr_i;
  assign hit_pend = (address_i == A_PEND);
  assign hit_en   = (address_i == A_EN);
  assign hit_vec  = (address_i == A_VEC);
  assign hit_eoi  = (address_i == A_EOI);
  assign hit_sw   = (address_i == A_SW);

  // A VECTOR read while asserting is the claim; a held read only claims on
  // its first cycle because the FSM has left ASSERT by the second.
  assign claim = rd & hit_vec & (state == ASSERT);

  // Pending update: sets are OR'd in after clears so a same-cycle edge or
  // SWTRIG survives a W1C or claim of the same bit.
  always_comb begin
    set_m = src_irq_i & ~src_q;
    if (wr & hit_sw) set_m = set_m | data_i[NS-1:0];
    clr_m = '0;
    if (wr & hit_pend) clr_m = data_i[NS-1:0];
    if (claim)         clr_m = clr_m | (NS'(1) << vec);
    pend_nx = (pending & ~clr_m) | set_m;
    en_nx   = (wr & hit_en) ? data_i[NS-1:0] : enable;
    live_nx = pend_nx & en_nx;
  end

  io_irq_prio_enc #(
    .WIDTH (NS),
    .IDXW  (IDXW)
  ) u_prio (
    .req   (pending & enable),
    .valid (enc_valid),
    .index (enc_idx)
  );

  always_comb begin
    rdata = '0;
    if (hit_pend) begin
      rdata = data_width'(pending);
    end else if (hit_en) begin
      rdata = data_width'(enable);
    end else if (hit_vec) begin
      rdata[IDXW-1:0]     = vec;
      rdata[data_width-1] = (state == ASSERT);
    end
  end

  // Register file and bus response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      src_q           <= '0;
      pending         <= '0;
      enable          <= '0;
      data_o          <= '0;
      take_controlr_o <= 1'b0;
      take_controlw_o <= 1'b0;
    end else begin
      src_q           <= src_irq_i;
      pending         <= pend_nx;
      enable          <= en_nx;
      take_controlw_o <= wr & (hit_pend | hit_en | hit_eoi | hit_sw);
      // Read outputs hold across write cycles.
      if (rd) begin
        data_o          <= rdata;
        take_controlr_o <= hit_pend | hit_en | hit_vec;
      end
    end
  end

  // Claim / EOI sequencer. The ASSERT drop test looks at next-cycle
  // pending/enable so a disable or W1C withdraws irq_o at the write edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      vec   <= '0;
      irq_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_valid) begin
            state <= ASSERT;
            vec   <= enc_idx;
            irq_o <= 1'b1;
          end
        end
        ASSERT: begin
          if (claim) begin
            state <= IN_SERVICE;
            irq_o <= 1'b0;
          end else if (!live_nx[vec]) begin
            state <= IDLE;
            irq_o <= 1'b0;
          end
        end
        IN_SERVICE: begin
          if (wr & hit_eoi) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_irq_ctrl.sv
// tb_io_irq_ctrl
//   Directed bench for io_irq_ctrl at base 'h9100, 8-bit data, 8 sources.
//   Inputs are driven 1 time unit after each rising edge and outputs are
//   sampled at the same point, so every check sees the state after an edge.
//   The bus idles as a write to unmapped address 0 (no effect, read data held).
module tb_io_irq_ctrl;

  localparam logic [15:0] BASE = 16'h9100;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        rd_wr_i;
  logic [7:0]  src_irq_i;
  logic [7:0]  data_o;
  logic        take_controlr_o, take_controlw_o, irq_o;

  int checks   = 0;
  int failures = 0;

  io_irq_ctrl #(
    .BaseAddress     ('h9100),
    .address_width   (16),
    .data_width      (8),
    .Address_Wording (1),
    .Num_Sources     (8)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .address_i       (address_i),
    .data_i          (data_i),
    .rd_wr_i         (rd_wr_i),
    .src_irq_i       (src_irq_i),
    .data_o          (data_o),
    .take_controlr_o (take_controlr_o),
    .take_controlw_o (take_controlw_o),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    address_i = 16'h0000;
    rd_wr_i   = 1'b1;
    data_i    = 8'h00;
  endtask

  task automatic bus_wr(input int ofs, input logic [7:0] d);
    address_i = BASE + 16'(ofs);
    rd_wr_i   = 1'b1;
    data_i    = d;
    tick();
    park();
  endtask

  task automatic bus_rd(input int ofs);
    address_i = BASE + 16'(ofs);
    rd_wr_i   = 1'b0;
    tick();
    park();
  endtask

  initial begin
    reset_i   = 1'b1;
    src_irq_i = 8'h00;
    park();
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    // Reset state
    chk("rst_data",   data_o, 8'h00);
    chk("rst_takeR",  8'(take_controlr_o), 8'h0);
    chk("rst_takeW",  8'(take_controlw_o), 8'h0);
    chk("rst_irq",    8'(irq_o), 8'h0);
    bus_rd(0);
    chk("rst_pend",   data_o, 8'h00);
    chk("rd_hit",     8'(take_controlr_o), 8'h1);

    // Basic flow
    bus_wr(1, 8'h0C);
    chk("wr_hit",     8'(take_controlw_o), 8'h1);
    src_irq_i = 8'h08;
    tick();
    chk("lat_k",      8'(irq_o), 8'h0);
    chk("wr_pulse",   8'(take_controlw_o), 8'h0);
    src_irq_i = 8'h00;
    tick();
    chk("lat_k1",     8'(irq_o), 8'h1);
    bus_rd(2);
    chk("claim3",     data_o, 8'h83);
    chk("claim3_irq", 8'(irq_o), 8'h0);
    bus_rd(0);
    chk("pend_clr3",  data_o, 8'h00);
    bus_wr(3, 8'h00);
    bus_rd(2);
    chk("idle_vec",   data_o, 8'h03);
    chk("idle_irq",   8'(irq_o), 8'h0);

    // Priority
    bus_wr(1, 8'hFF);
    src_irq_i = 8'h24;
    tick();
    src_irq_i = 8'h00;
    tick();
    chk("prio_irq",   8'(irq_o), 8'h1);
    bus_rd(2);
    chk("prio_v2",    data_o, 8'h82);
    bus_wr(3, 8'h00);
    chk("b2b_idle",   8'(irq_o), 8'h0);
    tick();
    chk("b2b_irq",    8'(irq_o), 8'h1);
    bus_rd(2);
    chk("prio_v5",    data_o, 8'h85);
    bus_wr(3, 8'h00);

    // Masking / W1C
    bus_wr(4, 8'h10);
    tick();
    chk("sw_irq",     8'(irq_o), 8'h1);
    bus_wr(1, 8'h00);
    tick();
    chk("mask_irq",   8'(irq_o), 8'h0);
    bus_rd(0);
    chk("mask_pend",  data_o, 8'h10);
    bus_wr(0, 8'h10);
    bus_rd(0);
    chk("w1c_pend",   data_o, 8'h00);

    // Collision (edge on source 0 during its claim) and held read
    bus_wr(1, 8'h01);
    bus_wr(4, 8'h01);
    tick();
    chk("col_irq",    8'(irq_o), 8'h1);
    address_i = BASE + 16'd2;
    rd_wr_i   = 1'b0;
    src_irq_i = 8'h01;
    tick();
    chk("held_r0",    data_o, 8'h80);
    tick();
    chk("held_r1",    data_o, 8'h00);
    tick();
    chk("held_r2",    data_o, 8'h00);
    park();
    bus_rd(0);
    chk("col_pend",   data_o, 8'h01);
    chk("insvc_irq",  8'(irq_o), 8'h0);
    bus_wr(0, 8'h01);
    bus_wr(3, 8'h00);
    src_irq_i = 8'h00;

    // Bus hits
    bus_rd(1);
    chk("en_rd",      data_o, 8'h01);
    tick();
    chk("hold_data",  data_o, 8'h01);
    chk("hold_takeR", 8'(take_controlr_o), 8'h1);
    address_i = 16'h9105;
    rd_wr_i   = 1'b0;
    tick();
    park();
    chk("unm_data",   data_o, 8'h00);
    chk("unm_takeR",  8'(take_controlr_o), 8'h0);
    bus_wr(3, 8'h00);
    chk("eoi_takeW",  8'(take_controlw_o), 8'h1);
    chk("eoi_irq",    8'(irq_o), 8'h0);
    tick();
    chk("eoi_pulse",  8'(take_controlw_o), 8'h0);
    chk("eoi_idle",   8'(irq_o), 8'h0);

    // Asynchronous reset while asserting
    bus_wr(4, 8'h01);
    bus_rd(1);
    chk("pre_rst_irq", 8'(irq_o), 8'h1);
    chk("pre_rst_dat", data_o, 8'h01);
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_irq",   8'(irq_o), 8'h0);
    chk("arst_data",  data_o, 8'h00);
    chk("arst_takeR", 8'(take_controlr_o), 8'h0);
    chk("arst_takeW", 8'(take_controlw_o), 8'h0);
    tick();
    reset_i = 1'b0;
    bus_rd(0);
    chk("arst_pend",  data_o, 8'h00);
    tick();
    chk("arst_noirq", 8'(irq_o), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
